// File: rtl/alu_pkg.sv
// Shared ALU op codes, R-type funct constants, sequencer state encoding and decode helpers
// used by the ALU control sequencer and its bench.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MULT = 4'd2;
  localparam logic [3:0] ALU_DIV  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_MOD  = 4'd8;

  localparam logic [5:0] F_ADD  = 6'h00;
  localparam logic [5:0] F_SUB  = 6'h02;
  localparam logic [5:0] F_MULT = 6'h08;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_AND  = 6'h04;
  localparam logic [5:0] F_OR   = 6'h05;
  localparam logic [5:0] F_XOR  = 6'h06;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_MOD  = 6'h07;

  localparam logic [3:0] ALU_CTRL_RTYPE = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic logic [3:0] alu_decode(input logic [3:0] ctrl, input logic [5:0] funct);
    logic [3:0] op;
    op = ALU_ADD;
    case (ctrl)
      4'd0: op = ALU_ADD;
      4'd1: op = ALU_SUB;
      4'd2: op = ALU_AND;
      4'd3: op = ALU_OR;
      4'd4: op = ALU_XOR;
      4'd5: op = ALU_SLT;
      ALU_CTRL_RTYPE: begin
        case (funct)
          F_ADD:   op = ALU_ADD;
          F_SUB:   op = ALU_SUB;
          F_MULT:  op = ALU_MULT;
          F_DIV:   op = ALU_DIV;
          F_AND:   op = ALU_AND;
          F_OR:    op = ALU_OR;
          F_XOR:   op = ALU_XOR;
          F_SLT:   op = ALU_SLT;
          F_MOD:   op = ALU_MOD;
          default: op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative radix-2 engine on unsigned magnitudes: shift-add multiply and restoring divide,
// one step per clock. acc_step_o is the value the accumulator takes on the next step.
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               mul_i,
  input  logic [WIDTH-1:0]   mag_a_i,
  input  logic [WIDTH-1:0]   mag_b_i,
  output logic [2*WIDTH-1:0] acc_step_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               mul_q, mul_d;
  logic [WIDTH:0]     add_sum, rem_sh, rem_dif;
  logic               q_bit;

  // Multiply: {hi, lo} with multiplier in lo. Divide: {remainder, dividend/quotient}.
  always_comb begin
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    rem_dif = rem_sh - {1'b0, opnd_q};
    q_bit   = ~rem_dif[WIDTH];
    if (mul_q) begin
      acc_step_o = {add_sum, acc_q[WIDTH-1:1]};
    end else begin
      acc_step_o = {(q_bit ? rem_dif[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit};
    end
  end

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    mul_d  = mul_q;
    if (load_i) begin
      acc_d  = {{WIDTH{1'b0}}, (mul_i ? mag_b_i : mag_a_i)};
      opnd_d = mul_i ? mag_a_i : mag_b_i;
      mul_d  = mul_i;
    end else if (step_i) begin
      acc_d = acc_step_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q  <= '0;
      opnd_q <= '0;
      mul_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      mul_q  <= mul_d;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes the ALU op code and runs mult/div/mod on an iterative engine,
// holding the core stalled while the engine is busy.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             inClk,
  input  logic             inRst_n,
  input  logic             inStart,
  input  logic [3:0]       inControl,
  input  logic [5:0]       inFunct,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [3:0]       outAlu,
  output logic             outStall,
  output logic             outBusy,
  output logic             outDone,
  output logic [WIDTH-1:0] outResult,
  output logic [WIDTH-1:0] outResultHi,
  output logic             outDivZero
);

  // state | meaning
  // IDLE  | waiting for a long op; short ops only decode
  // RUN   | engine stepping once per cycle, core stalled
  // DONE  | one-cycle result pulse, core commits and advances

  localparam int CNT_W = $clog2(WIDTH + 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic             sign_a_q, sign_b_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] res_q, res_hi_q;

  logic               long_op, accept, zero_div, neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_step, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign outAlu   = alu_decode(inControl, inFunct);
  assign long_op  = is_long_op(outAlu);
  assign accept   = (state_q == ST_IDLE) && inStart && long_op;
  assign zero_div = (outAlu != ALU_MULT) && (inB == '0);

  // The most negative value maps to itself, which is its correct unsigned magnitude.
  assign neg_a = SIGNED && inA[WIDTH-1];
  assign neg_b = SIGNED && inB[WIDTH-1];
  assign mag_a = neg_a ? -inA : inA;
  assign mag_b = neg_b ? -inB : inB;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_engine (
    .clk_i      (inClk),
    .rst_n_i    (inRst_n),
    .load_i     (accept && !zero_div),
    .step_i     (state_q == ST_RUN),
    .mul_i      (outAlu == ALU_MULT),
    .mag_a_i    (mag_a),
    .mag_b_i    (mag_b),
    .acc_step_o (acc_step)
  );

  // Corrections act on the final step's value so results are registered on entry to DONE.
  assign prod_s = (sign_a_q ^ sign_b_q) ? -acc_step : acc_step;
  assign quo_s  = (sign_a_q ^ sign_b_q) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  assign rem_s  = sign_a_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

  always_ff @(posedge inClk or negedge inRst_n) begin
    if (!inRst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= ALU_ADD;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= outAlu;
            sign_a_q <= neg_a;
            sign_b_q <= neg_b;
            cnt_q    <= CNT_W'(WIDTH);
            if (zero_div) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              dz_q     <= 1'b1;
              res_q    <= '1;
              res_hi_q <= inA;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              dz_q    <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            case (op_q)
              ALU_MULT: begin
                res_q    <= prod_s[WIDTH-1:0];
                res_hi_q <= prod_s[2*WIDTH-1:WIDTH];
              end
              ALU_DIV: begin
                res_q    <= quo_s;
                res_hi_q <= rem_s;
              end
              default: begin
                res_q    <= rem_s;
                res_hi_q <= rem_s;
              end
            endcase
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Gated by reset so the stall drops asynchronously even with a start still asserted.
  assign outStall    = (accept && inRst_n) || busy_q;
  assign outBusy     = busy_q;
  assign outDone     = done_q;
  assign outResult   = res_q;
  assign outResultHi = res_hi_q;
  assign outDivZero  = dz_q;

endmodule
